// File: rtl/pla_term_engine_if.sv
// rtl/pla_term_engine_if.sv - config, input and output stream bundle for pla_term_engine
// Purpose: groups the term-table config port, the input vector stream and the
//          result stream of pla_term_engine.
// Ports (master = driver side, slave = engine side):
//   cfg_we/cfg_addr/cfg_care/cfg_val/cfg_omask/cfg_en  term-table write
//   cfg_err                                            dropped-write pulse
//   in_valid/in_ready/in_x                             input vector stream
//   out_valid/out_ready/out_z                          result stream
//   busy                                               engine not idle
interface pla_term_engine_if #(
  parameter int N_IN    = 39,
  parameter int N_OUT   = 3,
  parameter int N_TERMS = 64
);
  localparam int AW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [N_IN-1:0]  cfg_care;
  logic [N_IN-1:0]  cfg_val;
  logic [N_OUT-1:0] cfg_omask;
  logic             cfg_en;
  logic             cfg_err;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_z;
  logic             busy;

  modport master (
    output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask, cfg_en,
    output in_valid, in_x, out_ready,
    input  cfg_err, in_ready, out_valid, out_z, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask, cfg_en,
    input  in_valid, in_x, out_ready,
    output cfg_err, in_ready, out_valid, out_z, busy
  );
endinterface

// File: rtl/pla_term_engine.sv
// rtl/pla_term_engine.sv - programmable product-term table evaluated LANES terms per cycle
// Purpose: holds N_TERMS product terms (care, value, output mask, enable),
//          evaluates an accepted input vector against them group by group and
//          returns the OR of the output masks of all matching terms.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pla_term_engine_if.slave: config port, input stream, result stream, busy
module pla_term_engine #(
  parameter int N_IN       = 39,
  parameter int N_OUT      = 3,
  parameter int N_TERMS    = 64,
  parameter int LANES      = 1,
  parameter int EARLY_EXIT = 1
) (
  input logic               clk,
  input logic               rst,
  pla_term_engine_if.slave  bus
);
  localparam int AW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_TERMS - LANES);
  localparam logic [AW-1:0] IDX_STEP = AW'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [N_IN-1:0]  r_care  [N_TERMS];
  logic [N_IN-1:0]  r_val   [N_TERMS];
  logic [N_OUT-1:0] r_omask [N_TERMS];
  logic [N_TERMS-1:0] r_en;

  logic [N_IN-1:0]  r_x;
  logic [AW-1:0]    r_idx;
  logic [N_OUT-1:0] r_acc;
  logic [N_OUT-1:0] r_out_z;
  logic             r_out_valid;
  logic             r_cfg_err;

  logic [AW-1:0]    w_tidx;
  logic [N_OUT-1:0] w_group_hit;
  logic [N_OUT-1:0] w_acc_next;
  logic             w_eval_last;
  logic             w_in_ready;
  logic             w_write;
  logic             w_accept;

  // OR of the output masks of the matching terms in the current group.
  always_comb begin
    w_group_hit = '0;
    w_tidx      = '0;
    for (int l = 0; l < LANES; l++) begin
      w_tidx = r_idx + AW'(l);
      if (r_en[w_tidx] && (((r_x ^ r_val[w_tidx]) & r_care[w_tidx]) == '0)) begin
        w_group_hit = w_group_hit | r_omask[w_tidx];
      end
    end
    w_acc_next  = r_acc | w_group_hit;
    // Once every output is set no further term can change the result.
    w_eval_last = (r_idx == LAST_IDX) || ((EARLY_EXIT != 0) && (&w_acc_next));
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A config write takes priority over a vector in the same cycle.
        w_in_ready = !bus.cfg_we;
        if (bus.in_valid && !bus.cfg_we) w_state_next = S_EVAL;
      end
      S_EVAL: if (w_eval_last) w_state_next = S_DONE;
      S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Writes are only taken in IDLE, so an in-flight vector always sees the
  // table as it was at its accept edge.
  assign w_write  = bus.cfg_we && (r_state == S_IDLE);
  assign w_accept = w_in_ready && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Term contents are deliberately not reset; only the enables are.
  always_ff @(posedge clk) begin
    if (!rst && w_write) begin
      r_care[bus.cfg_addr]  <= bus.cfg_care;
      r_val[bus.cfg_addr]   <= bus.cfg_val;
      r_omask[bus.cfg_addr] <= bus.cfg_omask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en        <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_z     <= '0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= bus.cfg_we && (r_state != S_IDLE);
      if (w_write) r_en[bus.cfg_addr] <= bus.cfg_en;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x   <= bus.in_x;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_EVAL: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + IDX_STEP;
          if (w_eval_last) begin
            r_out_z     <= w_acc_next;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: if (bus.out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.cfg_err   = r_cfg_err;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_out_z;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_pla_term_engine.sv
// tb/tb_pla_term_engine.sv - self-checking bench for pla_term_engine (early exit on and off)
module tb_pla_term_engine;
  localparam int N_IN = 4, N_OUT = 2, N_TERMS = 4, LANES = 1, G = N_TERMS / LANES;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pla_term_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) bus_a ();
  pla_term_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) bus_b ();

  assign bus_b.cfg_we    = bus_a.cfg_we;
  assign bus_b.cfg_addr  = bus_a.cfg_addr;
  assign bus_b.cfg_care  = bus_a.cfg_care;
  assign bus_b.cfg_val   = bus_a.cfg_val;
  assign bus_b.cfg_omask = bus_a.cfg_omask;
  assign bus_b.cfg_en    = bus_a.cfg_en;
  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_x      = bus_a.in_x;
  assign bus_b.out_ready = bus_a.out_ready;

  pla_term_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .LANES(LANES), .EARLY_EXIT(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  pla_term_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .LANES(LANES), .EARLY_EXIT(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // Reference table
  logic [3:0] m_care [N_TERMS];
  logic [3:0] m_val  [N_TERMS];
  logic [1:0] m_om   [N_TERMS];
  logic       m_en   [N_TERMS];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result is the OR of all matching masks; early-exit latency is the
  // number of terms visited until all outputs are set.
  task automatic model(input logic [3:0] x, output logic [1:0] z, output int lat_a);
    z = 2'b00;
    lat_a = G;
    for (int t = 0; t < N_TERMS; t++) begin
      if (m_en[t] && (((x ^ m_val[t]) & m_care[t]) == 4'b0000)) z = z | m_om[t];
      if (z == 2'b11 && lat_a == G) lat_a = t + 1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [3:0] c, input logic [3:0] v,
                           input logic [1:0] o, input logic e);
    bus_a.cfg_we = 1'b1; bus_a.cfg_addr = a; bus_a.cfg_care = c;
    bus_a.cfg_val = v; bus_a.cfg_omask = o; bus_a.cfg_en = e;
    step();
    bus_a.cfg_we = 1'b0;
    m_care[a] = c; m_val[a] = v; m_om[a] = o; m_en[a] = e;
    n_cmp++;
    if ({bus_a.cfg_err, bus_b.cfg_err} !== 2'b00) begin
      n_fail++; $display("FAIL cfg_err_idle: got %b want 00", {bus_a.cfg_err, bus_b.cfg_err});
    end
  endtask

  task automatic start_vec(input logic [3:0] x);
    bus_a.in_valid = 1'b1;
    bus_a.in_x = x;
    #1;
    n_cmp++;
    if ({bus_a.in_ready, bus_b.in_ready} !== 2'b11) begin
      n_fail++; $display("FAIL in_ready_accept: got %b want 11", {bus_a.in_ready, bus_b.in_ready});
    end
    step();
    bus_a.in_valid = 1'b0;
    bus_a.in_x = 4'($urandom);
  endtask

  // Waits for both results, counting edges since the accept edge.
  task automatic finish_vec(input string name, input logic [1:0] ez, input int ela,
                            input int pre, input int hold);
    int la = 0;
    int lb = 0;
    for (int n = pre; n <= pre + 20; n++) begin
      if (n > pre) step();
      if (bus_a.out_valid === 1'b1 && la == 0) la = n;
      if (bus_b.out_valid === 1'b1 && lb == 0) lb = n;
      if (la != 0 && lb != 0) break;
    end
    n_cmp++;
    if (la !== ela) begin n_fail++; $display("FAIL %s lat_early: got %0d want %0d", name, la, ela); end
    n_cmp++;
    if (lb !== G) begin n_fail++; $display("FAIL %s lat_full: got %0d want %0d", name, lb, G); end
    n_cmp++;
    if ({bus_a.out_z, bus_b.out_z} !== {ez, ez}) begin
      n_fail++; $display("FAIL %s out_z: got %b/%b want %b", name, bus_a.out_z, bus_b.out_z, ez);
    end
    for (int h = 0; h < hold; h++) begin
      step();
      n_cmp++;
      if ({bus_a.out_valid, bus_b.out_valid, bus_a.out_z, bus_b.out_z, bus_a.in_ready, bus_b.in_ready}
          !== {2'b11, ez, ez, 2'b00}) begin
        n_fail++;
        $display("FAIL %s hold%0d: valid=%b%b z=%b/%b in_ready=%b%b want valid=11 z=%b in_ready=00",
                 name, h, bus_a.out_valid, bus_b.out_valid, bus_a.out_z, bus_b.out_z,
                 bus_a.in_ready, bus_b.in_ready, ez);
      end
    end
    bus_a.out_ready = 1'b1;
    step();
    bus_a.out_ready = 1'b0;
    n_cmp++;
    if ({bus_a.out_valid, bus_b.out_valid, bus_a.busy, bus_b.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s release: valid=%b%b busy=%b%b want 0000", name,
               bus_a.out_valid, bus_b.out_valid, bus_a.busy, bus_b.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int t = 0; t < N_TERMS; t++) m_en[t] = 1'b0;
    n_cmp++;
    if ({bus_a.out_valid, bus_b.out_valid, bus_a.cfg_err, bus_b.cfg_err, bus_a.busy, bus_b.busy,
         bus_a.out_z, bus_b.out_z, bus_a.in_ready, bus_b.in_ready} !== {6'b0, 4'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b%b err=%b%b busy=%b%b z=%b/%b in_ready=%b%b",
               bus_a.out_valid, bus_b.out_valid, bus_a.cfg_err, bus_b.cfg_err, bus_a.busy,
               bus_b.busy, bus_a.out_z, bus_b.out_z, bus_a.in_ready, bus_b.in_ready);
    end
    start_vec(4'b1111);
    finish_vec("empty_table", 2'b00, G, 0, 0);
  endtask

  task automatic test_t1();
    cfg_write(2'd0, 4'b1100, 4'b1000, 2'b01, 1'b1);
    cfg_write(2'd1, 4'b0011, 4'b0011, 2'b10, 1'b1);
    start_vec(4'b1011);
    finish_vec("t1", 2'b11, 2, 0, 0);
  endtask

  task automatic test_t2_hold();
    start_vec(4'b0100);
    finish_vec("t2", 2'b00, G, 0, 5);
  endtask

  task automatic test_t3_early_exit();
    cfg_write(2'd0, 4'b0000, 4'b0000, 2'b11, 1'b1);
    start_vec(4'($urandom));
    finish_vec("t3", 2'b11, 1, 0, 0);
  endtask

  task automatic test_t4_cfg_busy();
    cfg_write(2'd0, 4'b1100, 4'b1000, 2'b01, 1'b1);
    start_vec(4'b1000);
    step();
    bus_a.cfg_we = 1'b1; bus_a.cfg_addr = 2'd1; bus_a.cfg_care = 4'b0000;
    bus_a.cfg_val = 4'b0000; bus_a.cfg_omask = 2'b10; bus_a.cfg_en = 1'b1;
    step();
    bus_a.cfg_we = 1'b0;
    n_cmp++;
    if ({bus_a.cfg_err, bus_b.cfg_err} !== 2'b11) begin
      n_fail++; $display("FAIL t4_cfg_err: got %b want 11", {bus_a.cfg_err, bus_b.cfg_err});
    end
    step();
    n_cmp++;
    if ({bus_a.cfg_err, bus_b.cfg_err} !== 2'b00) begin
      n_fail++; $display("FAIL t4_cfg_err_pulse: got %b want 00", {bus_a.cfg_err, bus_b.cfg_err});
    end
    finish_vec("t4_inflight", 2'b01, G, 3, 0);
    start_vec(4'b1000);
    finish_vec("t4_next", 2'b01, G, 0, 0);
  endtask

  task automatic test_t5_cfg_wins();
    bus_a.cfg_we = 1'b1; bus_a.cfg_addr = 2'd1; bus_a.cfg_care = 4'b0000;
    bus_a.cfg_val = 4'b0000; bus_a.cfg_omask = 2'b10; bus_a.cfg_en = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.in_x = 4'b1000;
    #1;
    n_cmp++;
    if ({bus_a.in_ready, bus_b.in_ready} !== 2'b00) begin
      n_fail++; $display("FAIL t5_in_ready: got %b want 00", {bus_a.in_ready, bus_b.in_ready});
    end
    step();
    bus_a.cfg_we = 1'b0;
    m_care[1] = 4'b0000; m_val[1] = 4'b0000; m_om[1] = 2'b10; m_en[1] = 1'b1;
    n_cmp++;
    if ({bus_a.busy, bus_b.busy} !== 2'b00) begin
      n_fail++; $display("FAIL t5_not_accepted: busy=%b want 00", {bus_a.busy, bus_b.busy});
    end
    start_vec(4'b1000);
    finish_vec("t5", 2'b11, 2, 0, 0);
  endtask

  task automatic test_t6_reset_mid_eval();
    cfg_write(2'd1, 4'b0011, 4'b0011, 2'b10, 1'b0);
    start_vec(4'b1000);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int t = 0; t < N_TERMS; t++) m_en[t] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if ({bus_a.out_valid, bus_b.out_valid, bus_a.busy, bus_b.busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL t6_discard%0d: valid=%b%b busy=%b%b want 0000", c,
                 bus_a.out_valid, bus_b.out_valid, bus_a.busy, bus_b.busy);
      end
      step();
    end
    start_vec(4'($urandom));
    finish_vec("t6_after", 2'b00, G, 0, 0);
  endtask

  task automatic test_random();
    logic [3:0] x;
    logic [1:0] z;
    int la;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write(2'($urandom_range(0, 3)), 4'($urandom & $urandom), 4'($urandom),
                  2'($urandom), ($urandom_range(0, 3) != 0));
      x = 4'($urandom);
      model(x, z, la);
      start_vec(x);
      finish_vec("random", z, la, 0, $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.cfg_we = 1'b0; bus_a.cfg_addr = '0; bus_a.cfg_care = '0; bus_a.cfg_val = '0;
    bus_a.cfg_omask = '0; bus_a.cfg_en = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_x = '0;
    bus_a.out_ready = 1'b0;
    test_reset();
    test_t1();
    test_t2_hold();
    test_t3_early_exit();
    test_t4_cfg_busy();
    test_t5_cfg_wins();
    test_t6_reset_mid_eval();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
